if_stage: RTL and testbench

//  Instruction fetch stage; supplies id_stage with 32-bit instructions and their PCs.

---
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage. Holds the PC, issues in-order fetches to
//            instruction memory, buffers the returned words and hands them to
//            decode over valid/ready. Redirects flush the stage.
// Revision : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter logic [63:0] PC_RESET   = 64'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [63:0]      pc_q;
  logic [63:0]      rsp_pc_q;
  logic [CNT_W-1:0] outst;
  logic [CNT_W-1:0] kill;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [63:0]      pc_mem   [FIFO_DEPTH];
  logic [31:0]      inst_mem [FIFO_DEPTH];

  logic [CNT_W:0]   credit;
  logic             req_fire;
  logic             push;
  logic             pop;
  logic [63:0]      redirect_aligned;

  // Buffered entries plus in-flight requests may never exceed the buffer depth,
  // which is what guarantees a response always has a slot to land in.
  assign credit           = {1'b0, outst} + {1'b0, count};
  assign imem_req_valid   = rst_n & ~redirect_valid & (credit < DEPTH_C);
  assign imem_req_addr    = pc_q;
  assign req_fire         = imem_req_valid & imem_req_ready;
  assign redirect_aligned = redirect_pc & ~64'h3;

  assign inst_valid = (count != '0) & ~redirect_valid;
  assign inst       = inst_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
  assign pop        = inst_valid & inst_ready;
  assign push       = imem_rsp_valid & (kill == '0) & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_RESET;
      rsp_pc_q <= PC_RESET;
      outst    <= '0;
      kill     <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_valid) begin
      // Every request still in flight belongs to the old path; a response
      // arriving this very cycle is dropped here and not counted again.
      pc_q     <= redirect_aligned;
      rsp_pc_q <= redirect_aligned;
      outst    <= outst - CNT_W'(imem_rsp_valid);
      kill     <= outst - CNT_W'(imem_rsp_valid);
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + 64'd4;
      end
      outst <= outst + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (imem_rsp_valid && (kill != '0)) begin
        kill <= kill - CNT_W'(1);
      end
      if (push) begin
        rsp_pc_q <= rsp_pc_q + 64'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc_q;
      inst_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: program-order reference model,
//            bench-side instruction memory and directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

  localparam logic [63:0] PC_RESET   = 64'h8000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  logic        hold;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [63:0] addr;
    int          ep;
  } ent_t;

  ent_t        memq[$];
  logic [63:0] expq[$];
  logic [63:0] req_log[$];
  logic [63:0] pop_log[$];
  logic [63:0] model_pc;
  int          epoch;

  if_stage #(.PC_RESET(PC_RESET), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory answers one cycle after acceptance, in order, unless held.
  always @(posedge clk) begin
    #2;
    if (rst_n && !hold && memq.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Reference model: instructions must come out in program order from the
  // latest redirect target; anything fetched under an older epoch is dropped.
  always @(negedge clk) begin
    logic exp_iv;
    ent_t e;
    if (!rst_n) begin
      memq.delete();
      expq.delete();
      model_pc = PC_RESET;
      epoch    = 0;
    end else begin
      exp_iv = (expq.size() != 0) && !redirect_valid;
      chk("req_valid", imem_req_valid,
          !redirect_valid && (memq.size() + expq.size() < FIFO_DEPTH));
      chk("req_addr", imem_req_addr, model_pc);
      chk("inst_valid", inst_valid, exp_iv);
      if (exp_iv) begin
        chk("inst_pc", inst_pc, expq[0]);
        chk("inst", inst, data_of(expq[0]));
      end
      if (exp_iv && inst_ready) begin
        pop_log.push_back(expq[0]);
        void'(expq.pop_front());
      end
      if (imem_rsp_valid && memq.size() != 0) begin
        e = memq.pop_front();
        if (!redirect_valid && e.ep == epoch) expq.push_back(e.addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        req_log.push_back(imem_req_addr);
        memq.push_back('{model_pc, epoch});
        model_pc = model_pc + 64'd4;
      end
      if (redirect_valid) begin
        epoch++;
        expq.delete();
        model_pc = redirect_pc & ~64'h3;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int p;
    rst_n = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; hold = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (2) step();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);

    // Streaming fetch
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    b = req_log.size(); p = pop_log.size();
    rst_n = 1'b1;
    repeat (12) step();
    chk("t1_req0", req_log[b],   64'h8000_0000);
    chk("t1_req1", req_log[b+1], 64'h8000_0004);
    chk("t1_req2", req_log[b+2], 64'h8000_0008);
    chk("t1_req3", req_log[b+3], 64'h8000_000C);
    chk("t1_pop0", pop_log[p],   64'h8000_0000);
    chk("t1_pop1", pop_log[p+1], 64'h8000_0004);
    chk("t1_pop2", pop_log[p+2], 64'h8000_0008);

    // Decode stalled from reset: buffer fills, fetching stops
    inst_ready = 1'b0;
    do_reset();
    b = req_log.size(); p = pop_log.size();
    repeat (8) step();
    chk("t2_nreq", req_log.size() - b, 2);
    #2;
    chk("t2_req_valid", imem_req_valid, 0);
    step();
    inst_ready = 1'b1;
    repeat (6) step();
    chk("t2_pop0", pop_log[p],   64'h8000_0000);
    chk("t2_pop1", pop_log[p+1], 64'h8000_0004);
    chk("t2_req2", req_log[b+2], 64'h8000_0008);

    // Memory not ready: request held stable
    imem_req_ready = 1'b0;
    do_reset();
    b = req_log.size();
    for (int i = 0; i < 3; i++) begin
      step();
      #2;
      chk("t3_req_valid", imem_req_valid, 1);
      chk("t3_req_addr", imem_req_addr, 64'h8000_0000);
    end
    chk("t3_nofire", req_log.size() - b, 0);
    step();
    imem_req_ready = 1'b1;
    repeat (4) step();
    chk("t3_req0", req_log[b],   64'h8000_0000);
    chk("t3_req1", req_log[b+1], 64'h8000_0004);

    // Redirect with two requests outstanding
    hold = 1'b1;
    do_reset();
    b = req_log.size(); p = pop_log.size();
    repeat (4) step();
    chk("t4_nreq", req_log.size() - b, 2);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    step();
    redirect_valid = 1'b0;
    #2;
    chk("t4_empty", inst_valid, 0);
    chk("t4_addr", imem_req_addr, 64'h8000_0100);
    step();
    hold = 1'b0;
    repeat (8) step();
    chk("t4_req2", req_log[b+2], 64'h8000_0100);
    chk("t4_pop0", pop_log[p],   64'h8000_0100);

    // Redirect in the same cycle as a response while decode is ready
    hold = 1'b1;
    do_reset();
    p = pop_log.size();
    repeat (4) step();
    hold = 1'b0;
    #2;
    chk("t5_rsp_a", imem_rsp_valid, 1);
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    #2;
    chk("t5_rsp_b", imem_rsp_valid, 1);
    chk("t5_iv_redir", inst_valid, 0);
    chk("t5_rv_redir", imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    #2;
    chk("t5_iv_after", inst_valid, 0);
    chk("t5_nopop", pop_log.size() - p, 0);
    repeat (8) step();
    chk("t5_pop0", pop_log[p], 64'h8000_0200);

    // Reset while the buffer is full
    inst_ready = 1'b0;
    do_reset();
    repeat (8) step();
    #2;
    chk("t6_full_iv", inst_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_iv", inst_valid, 0);
    chk("t6_rst_rv", imem_req_valid, 0);
    step();
    rst_n = 1'b1;
    b = req_log.size();
    repeat (4) step();
    chk("t6_req0", req_log[b], 64'h8000_0000);

    // Redirect to the top of the address space: PC wraps to zero
    inst_ready = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    b = req_log.size(); p = pop_log.size();
    repeat (10) step();
    chk("t7_req0", req_log[b],   64'hFFFF_FFFF_FFFF_FFFC);
    chk("t7_req1", req_log[b+1], 64'h0000_0000_0000_0000);
    chk("t7_pop1", pop_log[p+1], 64'h0000_0000_0000_0000);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
